mc_req_parser: RTL and testbench

- Downstream consumer of the 64-bit AXI-Stream that feeds the memcached header handler.
- Parses each request packet's 24-byte memcached binary header (exactly 3 full beats) into a metadata record, then forwards the body beats (extras/key/value) unchanged.
- Drops malformed packets, checks the declared body length against the bytes actually received, and keeps packet and error counters.

---
 rtl/mc_req_parser.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mc_req_parser.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_req_parser.sv
// Memcached binary request header parser: extracts the 24-byte header from a 64-bit
// AXI-Stream into a metadata record, forwards body beats, and counts packets/errors.
module mc_req_parser #(
    parameter logic [7:0]  MAGIC    = 8'h80,
    parameter logic [31:0] MAX_BODY = 32'd2048,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_tdata,
    input  logic [7:0]       s_tkeep,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [63:0]      m_tdata,
    output logic [7:0]       m_tkeep,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic [7:0]       hdr_opcode,
    output logic [15:0]      hdr_key_len,
    output logic [7:0]       hdr_ext_len,
    output logic [31:0]      hdr_body_len,
    output logic [31:0]      hdr_opaque,
    output logic [63:0]      hdr_cas,
    output logic             err_pulse,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        HDR2 = 3'd2,
        BODY = 3'd3,
        DROP = 3'd4
    } state_t;

    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, keep[i]};
        end
        return n;
    endfunction

    // Wire byte 0 sits in bits [7:0] but is the most significant byte of the field.
    function automatic logic [31:0] be32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [63:0] be64(input logic [63:0] x);
        return {be32(x[31:0]), be32(x[63:32])};
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic              s_tready_s;
    logic              m_tvalid_s;
    logic              xfer_s;
    logic              keep_full_s;
    logic              len_bad_s;
    logic              err_event_s;
    logic              load_hdr_s;
    logic [31:0]       need_len_s;
    logic [31:0]       body_total_s;

    logic [7:0]        opcode_r;
    logic [15:0]       key_len_r;
    logic [7:0]        ext_len_r;
    logic [31:0]       body_len_r;
    logic [31:0]       opaque_r;
    logic [31:0]       byte_cnt_r;

    logic              hdr_valid_r;
    logic [7:0]        hdr_opcode_r;
    logic [15:0]       hdr_key_len_r;
    logic [7:0]        hdr_ext_len_r;
    logic [31:0]       hdr_body_len_r;
    logic [31:0]       hdr_opaque_r;
    logic [63:0]       hdr_cas_r;
    logic              err_pulse_r;
    logic [CNT_W-1:0]  pkt_cnt_r;
    logic [CNT_W-1:0]  err_cnt_r;

    assign xfer_s       = s_tvalid && s_tready_s;
    assign keep_full_s  = (s_tkeep == 8'hFF);
    assign need_len_s   = {16'd0, key_len_r} + {24'd0, ext_len_r};
    assign len_bad_s    = (body_len_r > MAX_BODY) || (body_len_r < need_len_s);
    assign body_total_s = byte_cnt_r + {28'd0, keep_popcount(s_tkeep)};

    // Input ready: beat2 waits for a free metadata slot, body follows downstream ready.
    always_comb begin
        s_tready_s = 1'b0;
        case (state_r)
            HDR0, HDR1, DROP: s_tready_s = 1'b1;
            HDR2:             s_tready_s = !hdr_valid_r || hdr_ready;
            BODY:             s_tready_s = m_tready;
            default:          s_tready_s = 1'b0;
        endcase
    end

    // Next-state, error detection and header-load decisions.
    always_comb begin
        state_s     = state_r;
        err_event_s = 1'b0;
        load_hdr_s  = 1'b0;
        m_tvalid_s  = 1'b0;
        case (state_r)
            HDR0: begin
                if (xfer_s) begin
                    if (!keep_full_s || s_tlast || (s_tdata[7:0] != MAGIC)) begin
                        err_event_s = 1'b1;
                        state_s     = s_tlast ? HDR0 : DROP;
                    end else begin
                        state_s = HDR1;
                    end
                end else begin
                    state_s = HDR0;
                end
            end
            HDR1: begin
                if (xfer_s) begin
                    if (!keep_full_s || s_tlast) begin
                        err_event_s = 1'b1;
                        state_s     = s_tlast ? HDR0 : DROP;
                    end else begin
                        state_s = HDR2;
                    end
                end else begin
                    state_s = HDR1;
                end
            end
            HDR2: begin
                if (xfer_s) begin
                    if (!keep_full_s || len_bad_s) begin
                        err_event_s = 1'b1;
                        state_s     = s_tlast ? HDR0 : DROP;
                    end else begin
                        load_hdr_s = 1'b1;
                        if (s_tlast) begin
                            // Header-only packet is only legal with an empty body.
                            err_event_s = (body_len_r != 32'd0);
                            state_s     = HDR0;
                        end else begin
                            state_s = BODY;
                        end
                    end
                end else begin
                    state_s = HDR2;
                end
            end
            BODY: begin
                m_tvalid_s = s_tvalid;
                if (xfer_s && s_tlast) begin
                    err_event_s = (body_total_s != body_len_r);
                    state_s     = HDR0;
                end else begin
                    state_s = BODY;
                end
            end
            DROP: begin
                if (xfer_s && s_tlast) begin
                    state_s = HDR0;
                end else begin
                    state_s = DROP;
                end
            end
            default: state_s = HDR0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HDR0;
        end else begin
            state_r <= state_s;
        end
    end

    // Staging of beat0/beat1 fields until beat2 completes the header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_r   <= 8'd0;
            key_len_r  <= 16'd0;
            ext_len_r  <= 8'd0;
            body_len_r <= 32'd0;
            opaque_r   <= 32'd0;
        end else if (xfer_s && (state_r == HDR0)) begin
            opcode_r  <= s_tdata[15:8];
            key_len_r <= {s_tdata[23:16], s_tdata[31:24]};
            ext_len_r <= s_tdata[39:32];
        end else if (xfer_s && (state_r == HDR1)) begin
            body_len_r <= be32(s_tdata[31:0]);
            opaque_r   <= be32(s_tdata[63:32]);
        end
    end

    // Metadata slot: loaded on a good beat2, freed by hdr_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_valid_r    <= 1'b0;
            hdr_opcode_r   <= 8'd0;
            hdr_key_len_r  <= 16'd0;
            hdr_ext_len_r  <= 8'd0;
            hdr_body_len_r <= 32'd0;
            hdr_opaque_r   <= 32'd0;
            hdr_cas_r      <= 64'd0;
        end else if (load_hdr_s) begin
            hdr_valid_r    <= 1'b1;
            hdr_opcode_r   <= opcode_r;
            hdr_key_len_r  <= key_len_r;
            hdr_ext_len_r  <= ext_len_r;
            hdr_body_len_r <= body_len_r;
            hdr_opaque_r   <= opaque_r;
            hdr_cas_r      <= be64(s_tdata);
        end else if (hdr_ready) begin
            hdr_valid_r <= 1'b0;
        end
    end

    // Body byte counter, cleared on the last body transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r <= 32'd0;
        end else if (xfer_s && (state_r == BODY)) begin
            byte_cnt_r <= s_tlast ? 32'd0 : body_total_s;
        end
    end

    // Error pulse and wrapping packet/error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_r <= 1'b0;
            pkt_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            err_pulse_r <= err_event_s;
            if (load_hdr_s) begin
                pkt_cnt_r <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (err_event_s) begin
                err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign s_tready     = s_tready_s;
    assign m_tdata      = s_tdata;
    assign m_tkeep      = s_tkeep;
    assign m_tlast      = s_tlast;
    assign m_tvalid     = m_tvalid_s;
    assign hdr_valid    = hdr_valid_r;
    assign hdr_opcode   = hdr_opcode_r;
    assign hdr_key_len  = hdr_key_len_r;
    assign hdr_ext_len  = hdr_ext_len_r;
    assign hdr_body_len = hdr_body_len_r;
    assign hdr_opaque   = hdr_opaque_r;
    assign hdr_cas      = hdr_cas_r;
    assign err_pulse    = err_pulse_r;
    assign pkt_cnt      = pkt_cnt_r;
    assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_mc_req_parser.sv
// Bench for mc_req_parser: directed plan packets plus random packets checked against
// a packet-level reference model of the parsing rules.
module tb_mc_req_parser;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] kl;
        logic [7:0]  el;
        logic [31:0] bl;
        logic [31:0] opq;
        logic [63:0] cas;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_opcode;
    logic [15:0] hdr_key_len;
    logic [7:0]  hdr_ext_len;
    logic [31:0] hdr_body_len;
    logic [31:0] hdr_opaque;
    logic [63:0] hdr_cas;
    logic        err_pulse;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    int    passed = 0;
    int    total  = 0;
    int    fails  = 0;
    int    err_seen = 0;
    int    exp_pkt_total = 0;
    int    exp_err_total = 0;
    bit    rnd_m = 1'b0;
    bit    rnd_h = 1'b0;
    beat_t pkt_q[$];
    beat_t m_q[$];
    hdr_t  hdr_q[$];
    logic [7:0] body_b[$];
    bit    exp_ok;
    bit    exp_err;
    hdr_t  exp_hdr;

    mc_req_parser dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_opcode(hdr_opcode),
        .hdr_key_len(hdr_key_len), .hdr_ext_len(hdr_ext_len), .hdr_body_len(hdr_body_len),
        .hdr_opaque(hdr_opaque), .hdr_cas(hdr_cas),
        .err_pulse(err_pulse), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Transfer monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) m_q.push_back({m_tdata, m_tkeep, m_tlast});
        if (hdr_valid && hdr_ready)
            hdr_q.push_back({hdr_opcode, hdr_key_len, hdr_ext_len, hdr_body_len, hdr_opaque, hdr_cas});
        if (err_pulse) err_seen++;
    end

    // Random backpressure on the body and metadata outputs when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rnd_m) m_tready = ($urandom_range(0, 1) == 1);
        if (rnd_h) hdr_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] x);
        return {bswap32(x[31:0]), bswap32(x[63:32])};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_body(input int n);
        body_b.delete();
        for (int i = 0; i < n; i++) body_b.push_back(8'($urandom));
    endtask

    task automatic build_pkt(input logic [7:0] magic, input logic [7:0] op, input logic [7:0] el,
                             input logic [15:0] kl, input logic [31:0] bl, input logic [31:0] opq,
                             input logic [63:0] cas, input logic [23:0] junk);
        logic [63:0] d;
        logic [7:0]  k;
        beat_t       b;
        pkt_q.delete();
        pkt_q.push_back({{junk, el, kl[7:0], kl[15:8], op, magic}, 8'hFF, 1'b0});
        pkt_q.push_back({{bswap32(opq), bswap32(bl)}, 8'hFF, 1'b0});
        pkt_q.push_back({bswap64(cas), 8'hFF, 1'b0});
        for (int i = 0; i < body_b.size(); i += 8) begin
            d = 64'd0;
            k = 8'd0;
            for (int j = 0; j < 8 && i + j < body_b.size(); j++) begin
                d[8*j +: 8] = body_b[i+j];
                k[j] = 1'b1;
            end
            pkt_q.push_back({d, k, 1'b0});
        end
        b = pkt_q[pkt_q.size()-1];
        b.l = 1'b1;
        pkt_q[pkt_q.size()-1] = b;
    endtask

    // Reference: decide the whole-packet outcome from the header parsing rules.
    task automatic model_pkt();
        int      n;
        longint  bytes;
        n = pkt_q.size();
        exp_ok  = (n >= 3);
        exp_err = 1'b0;
        exp_hdr = '0;
        for (int i = 0; i < n && i < 3; i++) if (pkt_q[i].k != 8'hFF) exp_ok = 1'b0;
        if (pkt_q[0].d[7:0] != 8'h80) exp_ok = 1'b0;
        if (n >= 3) begin
            exp_hdr.op  = pkt_q[0].d[15:8];
            exp_hdr.kl  = {pkt_q[0].d[23:16], pkt_q[0].d[31:24]};
            exp_hdr.el  = pkt_q[0].d[39:32];
            exp_hdr.bl  = bswap32(pkt_q[1].d[31:0]);
            exp_hdr.opq = bswap32(pkt_q[1].d[63:32]);
            exp_hdr.cas = bswap64(pkt_q[2].d);
            if (longint'(exp_hdr.bl) > 64'd2048 ||
                longint'(exp_hdr.bl) < longint'(exp_hdr.kl) + longint'(exp_hdr.el)) exp_ok = 1'b0;
        end
        if (!exp_ok) begin
            exp_err = 1'b1;
        end else begin
            bytes = 0;
            for (int i = 3; i < n; i++) bytes += $countones(pkt_q[i].k);
            exp_err = (bytes != longint'(exp_hdr.bl));
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_beat(input beat_t b);
        int n;
        s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l; s_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 1000) begin
                chk("beat_timeout", 64'(s_tready), 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input bit gaps);
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive_beat(pkt_q[i]);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic check_pkt(input string tag);
        int    exp_h;
        int    exp_b;
        int    nb;
        hdr_t  h;
        model_pkt();
        exp_h = exp_ok ? 1 : 0;
        exp_b = exp_ok ? pkt_q.size() - 3 : 0;
        for (int i = 0; i < 300 && hdr_q.size() < exp_h; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        if (exp_ok) exp_pkt_total++;
        if (exp_err) exp_err_total++;
        chk({tag, "/hdr_count"}, 64'(hdr_q.size()), 64'(exp_h));
        if (exp_ok && hdr_q.size() > 0) begin
            h = hdr_q.pop_front();
            chk({tag, "/opcode"},   64'(h.op),  64'(exp_hdr.op));
            chk({tag, "/key_len"},  64'(h.kl),  64'(exp_hdr.kl));
            chk({tag, "/ext_len"},  64'(h.el),  64'(exp_hdr.el));
            chk({tag, "/body_len"}, 64'(h.bl),  64'(exp_hdr.bl));
            chk({tag, "/opaque"},   64'(h.opq), 64'(exp_hdr.opq));
            chk({tag, "/cas"},      h.cas,      exp_hdr.cas);
        end
        chk({tag, "/body_beats"}, 64'(m_q.size()), 64'(exp_b));
        nb = (m_q.size() < exp_b) ? m_q.size() : exp_b;
        for (int i = 0; i < nb; i++) begin
            chk({tag, "/body_data"}, m_q[i].d, pkt_q[i+3].d);
            chk({tag, "/body_keep"}, 64'(m_q[i].k), 64'(pkt_q[i+3].k));
            chk({tag, "/body_last"}, 64'(m_q[i].l), 64'(pkt_q[i+3].l));
        end
        chk({tag, "/err_pulses"}, 64'(err_seen), 64'(exp_err_total));
        chk({tag, "/pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt_total % 65536));
        chk({tag, "/err_cnt"}, 64'(err_cnt), 64'(exp_err_total % 65536));
        hdr_q.delete();
        m_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic get_foo(input logic [7:0] magic, input logic [31:0] opq);
        body_b.delete();
        body_b.push_back(8'h66); body_b.push_back(8'h6F); body_b.push_back(8'h6F);
        build_pkt(magic, 8'h00, 8'h00, 16'd3, 32'd3, opq, 64'd0, 24'd0);
    endtask

    initial begin
        beat_t b;
        int    mode;
        int    kl, el, vl, bl, nbytes;
        rst_n = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b0; hdr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst/m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst/err_pulse", 64'(err_pulse), 64'd0);
        chk("rst/pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst/err_cnt", 64'(err_cnt), 64'd0);
        chk("rst/hdr_body_len", 64'(hdr_body_len), 64'd0);
        chk("rst/hdr_cas", hdr_cas, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b1; hdr_ready = 1'b1;

        get_foo(8'h80, 32'hDEADBEEF);
        chk("get_foo/beat0", pkt_q[0].d, 64'h0000_0000_0300_0080);
        chk("get_foo/beat1", pkt_q[1].d, 64'hEFBE_ADDE_0300_0000);
        send_pkt(1'b0);
        check_pkt("get_foo");

        get_foo(8'h81, 32'h0BAD_0BAD);
        send_pkt(1'b0);
        check_pkt("bad_magic");
        get_foo(8'h80, 32'h1234_5678);
        send_pkt(1'b0);
        check_pkt("after_bad");

        body_b.delete();
        build_pkt(8'h80, 8'h0A, 8'h00, 16'd0, 32'd0, 32'hAAAA_0000, 64'h0102_0304_0506_0708, 24'd0);
        send_pkt(1'b0);
        check_pkt("hdr_only_0");
        build_pkt(8'h80, 8'h0A, 8'h00, 16'd0, 32'd8, 32'hAAAA_0008, 64'hFFEE_DDCC_BBAA_9988, 24'd0);
        send_pkt(1'b0);
        check_pkt("hdr_only_8");

        // Two back-to-back packets with the metadata slot held full.
        hdr_ready = 1'b0;
        get_foo(8'h80, 32'h1111_1111);
        send_pkt(1'b0);
        get_foo(8'h80, 32'h2222_2222);
        drive_beat(pkt_q[0]);
        drive_beat(pkt_q[1]);
        b = pkt_q[2];
        s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l; s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall/s_tready", 64'(s_tready), 64'd0);
        end
        chk("stall/hdr_valid", 64'(hdr_valid), 64'd1);
        @(posedge clk); #1;
        hdr_ready = 1'b1;
        @(negedge clk);
        chk("stall/release", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
        drive_beat(pkt_q[3]);
        s_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        exp_pkt_total += 2;
        chk("stall/hdr_count", 64'(hdr_q.size()), 64'd2);
        if (hdr_q.size() == 2) begin
            chk("stall/first_opaque", 64'(hdr_q[0].opq), 64'h1111_1111);
            chk("stall/second_opaque", 64'(hdr_q[1].opq), 64'h2222_2222);
        end
        chk("stall/body_beats", 64'(m_q.size()), 64'd2);
        chk("stall/pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_total));
        chk("stall/err_cnt", 64'(err_cnt), 64'(exp_err_total));
        hdr_q.delete(); m_q.delete();
        @(posedge clk); #1;

        // Declared 16 bytes, 24 delivered, downstream backpressure.
        rnd_m = 1'b1;
        rand_body(24);
        build_pkt(8'h80, 8'h01, 8'h00, 16'd8, 32'd16, 32'h5555_AAAA, 64'd77, 24'h123456);
        send_pkt(1'b1);
        check_pkt("len_mismatch");
        rnd_m = 1'b0;
        @(posedge clk); #1;
        m_tready = 1'b1;

        // Reset while a body beat is waiting.
        hdr_ready = 1'b0;
        get_foo(8'h80, 32'hCAFE_F00D);
        drive_beat(pkt_q[0]);
        drive_beat(pkt_q[1]);
        drive_beat(pkt_q[2]);
        b = pkt_q[3];
        s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l; s_tvalid = 1'b1;
        m_tready = 1'b0;
        @(negedge clk);
        chk("midrst/m_tvalid_before", 64'(m_tvalid), 64'd1);
        chk("midrst/hdr_valid_before", 64'(hdr_valid), 64'd1);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("midrst/m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst/hdr_valid", 64'(hdr_valid), 64'd0);
        chk("midrst/pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("midrst/err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b1; hdr_ready = 1'b1;
        hdr_q.delete(); m_q.delete();
        err_seen = 0; exp_pkt_total = 0; exp_err_total = 0;
        get_foo(8'h80, 32'hDEADBEEF);
        send_pkt(1'b0);
        check_pkt("post_rst");

        // Random packets with random corruptions and backpressure.
        rnd_m = 1'b1; rnd_h = 1'b1;
        for (int p = 0; p < 60; p++) begin
            kl = $urandom_range(0, 10);
            el = $urandom_range(0, 8);
            vl = $urandom_range(0, 24);
            bl = kl + el + vl;
            nbytes = bl;
            mode = $urandom_range(0, 9);
            if (mode == 3) bl = 3000;
            if (mode == 4) nbytes = (bl > 0 && $urandom_range(0, 1) == 1) ? bl - 1 : bl + $urandom_range(1, 9);
            if (mode == 5 && kl + el > 0) begin bl = kl + el - 1; nbytes = bl; end
            rand_body(nbytes);
            build_pkt((mode == 0) ? 8'h80 ^ 8'($urandom_range(1, 255)) : 8'h80, 8'($urandom),
                      8'(el), 16'(kl), 32'(bl), $urandom, {$urandom, $urandom}, 24'($urandom));
            if (mode == 1) begin
                int hb;
                hb = $urandom_range(0, 2);
                b = pkt_q[hb];
                b.k = 8'hFF & ~(8'h01 << $urandom_range(0, 7));
                pkt_q[hb] = b;
            end
            if (mode == 2) begin
                int keep_n;
                keep_n = $urandom_range(1, 2);
                while (pkt_q.size() > keep_n) void'(pkt_q.pop_back());
                b = pkt_q[keep_n-1];
                b.l = 1'b1;
                pkt_q[keep_n-1] = b;
            end
            send_pkt(1'b1);
            check_pkt($sformatf("rand%0d", p));
        end
        rnd_m = 1'b0; rnd_h = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
